// File: rtl/io_pkg.sv
// Shared encodings for the I/O handshake responder: FSM states, the
// write-back select value for Input, and the I/O opcodes it serves.
package io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_PRESS   = 3'd1,
        ST_CAPTURE      = 3'd2,
        ST_WAIT_RELEASE = 3'd3,
        ST_HALTED       = 3'd4
    } io_state_t;

    localparam logic [1:0] MEMTOREG_INPUT = 2'b11;

    localparam logic [5:0] OP_INPUT  = 6'b001100;
    localparam logic [5:0] OP_OUTPUT = 6'b001101;
    localparam logic [5:0] OP_HALT   = 6'b111111;

endpackage

// File: rtl/io_debounce.sv
// Enter-button conditioner: two-flop synchronizer followed by a counter that
// accepts a new level after DEBOUNCE_CYCLES consecutive matching samples.
module io_debounce
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press_accepted,
    output logic release_accepted
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic          level_reg;
    logic [CW-1:0] count_reg;
    logic          press_reg;
    logic          release_reg;

    // The accept pulse is registered, so the FSM reacts one edge after the
    // last counted sample: total latency is DEBOUNCE_CYCLES + 2 edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg    <= 2'b00;
            level_reg   <= 1'b0;
            count_reg   <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], btn};
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            if (sync_reg[1] == level_reg) begin
                count_reg <= '0;
            end else if (count_reg == LAST) begin
                level_reg   <= sync_reg[1];
                count_reg   <= '0;
                press_reg   <= sync_reg[1];
                release_reg <= ~sync_reg[1];
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign press_accepted   = press_reg;
    assign release_accepted = release_reg;

endmodule

// File: rtl/io_handshake_unit.sv
// Peripheral responder for Input/Output/HALT: stalls the core until the
// operator presses Enter, returns the switches, latches Output values.
module io_handshake_unit
    import io_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  input_flag,
    input  logic                  output_flag,
    input  logic                  halt,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic                  enter_btn,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] display_value,
    output logic                  display_valid,
    output logic                  in_wait,
    output logic                  halted
);

    io_state_t             state_reg;
    logic [DATA_WIDTH-1:0] in_data_reg;
    logic [DATA_WIDTH-1:0] display_value_reg;
    logic                  display_valid_reg;
    logic                  in_wait_reg;
    logic                  halted_reg;
    logic                  stall_comb;
    logic                  display_write;
    logic                  press_accepted;
    logic                  release_accepted;

    io_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock            (clock),
        .reset            (reset),
        .btn              (enter_btn),
        .press_accepted   (press_accepted),
        .release_accepted (release_accepted)
    );

    // Mealy stall in IDLE/WAIT_RELEASE so the core freezes in the flag cycle.
    always_comb begin
        stall_comb = 1'b0;
        case (state_reg)
            ST_IDLE, ST_WAIT_RELEASE: stall_comb = input_flag;
            ST_WAIT_PRESS, ST_HALTED: stall_comb = 1'b1;
            default:                  stall_comb = 1'b0;
        endcase
        if (reset) begin
            stall_comb = 1'b0;
        end
    end

    // Output yields to halt and input; a stalled cycle never writes.
    assign display_write = output_flag && !stall_comb && !halt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            in_data_reg       <= '0;
            display_value_reg <= '0;
            display_valid_reg <= 1'b0;
            in_wait_reg       <= 1'b0;
            halted_reg        <= 1'b0;
        end else begin
            if (display_write) begin
                display_value_reg <= out_data;
                display_valid_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (halt) begin
                        state_reg  <= ST_HALTED;
                        halted_reg <= 1'b1;
                    end else if (input_flag) begin
                        state_reg   <= ST_WAIT_PRESS;
                        in_wait_reg <= 1'b1;
                    end
                end
                ST_WAIT_PRESS: begin
                    if (press_accepted) begin
                        state_reg   <= ST_CAPTURE;
                        in_wait_reg <= 1'b0;
                        in_data_reg <= DATA_WIDTH'(switches);
                    end
                end
                ST_CAPTURE: begin
                    if (halt) begin
                        state_reg  <= ST_HALTED;
                        halted_reg <= 1'b1;
                    end else begin
                        state_reg <= ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (halt) begin
                        state_reg  <= ST_HALTED;
                        halted_reg <= 1'b1;
                    end else if (release_accepted) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    state_reg <= ST_HALTED;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    in_wait_reg <= 1'b0;
                    halted_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign stall         = stall_comb;
    assign in_data       = in_data_reg;
    assign display_value = display_value_reg;
    assign display_valid = display_valid_reg;
    assign in_wait       = in_wait_reg;
    assign halted        = halted_reg;

endmodule

// File: doc/io_handshake_unit.md
# io_handshake_unit

Peripheral-side responder for the processor's I/O instructions. It consumes the control unit's `input_flag`, `output_flag` and `halt` decodes and stalls the core on an Input instruction until the operator presses a debounced Enter button. It then returns the switch value for the register write-back path (memtoReg = 11), latches register values for display on Output, and freezes the core on HALT.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register/datapath width.
- `SW_WIDTH`, 16: switch bank width; must be ≤ `DATA_WIDTH`.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a button level; must be ≥ 1.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `input_flag` in 1: Input instruction in decode.
- `output_flag` in 1: Output instruction in decode.
- `halt` in 1: HALT instruction in decode.
- `switches` in `SW_WIDTH`: operator data, quasi-static.
- `enter_btn` in 1: raw asynchronous push-button, high = pressed.
- `out_data` in `DATA_WIDTH`: register-file read value for Output.
- `stall` out 1: high = hold PC and suppress regWrite/memWrite.
- `in_data` out `DATA_WIDTH`: zero-extended captured switches.
- `display_value` out `DATA_WIDTH`: last Output value.
- `display_valid` out 1: sticky; set by the first Output.
- `in_wait` out 1: operator prompt LED, high while waiting for a press.
- `halted` out 1: core frozen by HALT.

## Operation
- `enter_btn` passes through a 2-flop synchronizer and then the debouncer. The debouncer counts consecutive edges where the synchronized level equals the target level. Any mismatch clears the count.
- FSM states: IDLE, WAIT_PRESS, CAPTURE, WAIT_RELEASE, HALTED.
- Flag priority when more than one is high (illegal from the decoder, still defined): halt > input > output.
- IDLE:
  - `halt` → HALTED.
  - `input_flag` → WAIT_PRESS. `stall` goes high combinationally in the same cycle.
  - `output_flag` → display registers updated; state unchanged.
- WAIT_PRESS:
  - `stall` = 1 and `in_wait` = 1.
  - When the debounced press is accepted → CAPTURE. On that edge, `in_data` ← zero-extended `switches`.
- CAPTURE:
  - Lasts one cycle with `stall` = 0, so the core commits the write of `in_data` and advances.
  - Unconditionally → WAIT_RELEASE. `halt` or `output_flag` seen in this cycle are honoured as in IDLE.
- WAIT_RELEASE:
  - Waits for a debounced release, then → IDLE.
  - `stall` = `input_flag`. A second Input is held off until the button has been released.
  - `output_flag` and `halt` are handled as in IDLE.
- HALTED:
  - `stall` = 1 and `halted` = 1 until reset.
  - All flags and the button are ignored.
- Output: on a clock edge where `output_flag` = 1 and `stall` = 0, `display_value` ← `out_data` and `display_valid` ← 1.
- Reset (any time, including mid-wait):
  - State → IDLE; synchronizer and counter cleared.
  - All outputs 0: `stall`, `in_data`, `display_value`, `display_valid`, `in_wait`, `halted`.

## Timing
- Input is accepted exactly `DEBOUNCE_CYCLES` + 2 rising edges after the first edge that samples `enter_btn` high (2 synchronizer edges + debounce count), provided the button stays high.
  - CAPTURE is entered on that edge.
  - `in_data` is valid from that edge onward and held until the next capture.
- `stall` is low for exactly one cycle (CAPTURE) per accepted press.
- Release acceptance uses the same latency.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never causes a transition.
- Output write latency: one edge; no stall.
- `stall` is a Mealy output in IDLE and WAIT_RELEASE. The core must sample it in the same cycle.

## Structure
- Shared package `io_pkg` holds:
  - FSM state encoding (3 bits: IDLE=0, WAIT_PRESS=1, CAPTURE=2, WAIT_RELEASE=3, HALTED=4);
  - the memtoReg input-select constant 2'b11;
  - the opcode constants for Input, Output and HALT (6'b001100, 6'b001101, 6'b111111).
- One natural sub-module, `io_debounce`: synchronizer, counter, and a single-cycle `press_accepted`/`release_accepted` pulse. It is parameterized by `DEBOUNCE_CYCLES`.

## Test plan
- Reset mid-WAIT_PRESS with the button half-debounced → all outputs 0 and state IDLE; the next `input_flag` restarts a full `DEBOUNCE_CYCLES` + 2 count.
- `input_flag`=1, `switches`=16'hA5C3, `DEBOUNCE_CYCLES`=4, button held from edge 0:
  - `stall` high from the flag cycle;
  - CAPTURE at edge 6 with `in_data`=32'h0000A5C3;
  - `stall` low for one cycle, then WAIT_RELEASE.
- Button bounce high-low-high with 2-cycle high runs → no capture; a stable 4-sample high then captures.
- Back-to-back Inputs with the button still held → second Input is stalled until release is debounced, then waits for a new press.
- `output_flag`=1, `out_data`=32'hDEADBEEF during WAIT_RELEASE → `display_value`=32'hDEADBEEF and `display_valid`=1 on the next edge; no stall.
- `halt`=1 → `halted` and `stall` are 1 from the next edge. Later `input_flag` and button presses have no effect; only reset clears it.
